jt7759_rom_resp: RTL

ROM-side responder for the JT7759 control unit. It accepts byte requests on the `rom_cs`/`rom_addr` interface and returns `rom_data`/`rom_ok`. Requests are served from a two-word buffer with sequential prefetch. Misses are fetched from a 16-bit-wide external memory using a req/ack handshake. It sits between the JT7759 core and the system SDRAM/BRAM arbiter.

---
 rtl/jt7759_rom_resp.sv | 118 +++++++++++
 1 files changed

// File: rtl/jt7759_rom_resp.sv
// JT7759 ROM responder: two-entry word buffer with LRU fill,
// sequential prefetch and a req/ack fetch port to 16-bit memory.
`timescale 1ns/1ps
module jt7759_rom_resp #(
  parameter bit PREFETCH = 1'b1
) (
  input  logic        rst,
  input  logic        clk,
  input  logic        rom_cs,
  input  logic [16:0] rom_addr,
  output logic [7:0]  rom_data,
  output logic        rom_ok,
  input  logic        flush,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  input  logic        mem_ack,
  input  logic [15:0] mem_data
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    PREF
  } state_t;

  state_t      state_q;
  logic [1:0]  valid_q;
  logic [15:0] tag_q  [2];
  logic [15:0] word_q [2];
  logic        lru_q;
  logic        req_q;
  logic [15:0] maddr_q;
  logic        discard_q;
  logic        ok_q;
  logic [7:0]  data_q;
  logic [16:0] addr_q;

  logic [15:0] cur_d;
  logic [15:0] nxt_d;
  logic        hit0_d;
  logic        hit1_d;
  logic        hit_d;
  logic        nbuf_d;
  logic [15:0] sel_d;
  logic [7:0]  byte_d;

  always_comb begin
    cur_d  = rom_addr[16:1];
    nxt_d  = cur_d + 16'd1;
    hit0_d = valid_q[0] && (tag_q[0] == cur_d);
    hit1_d = valid_q[1] && (tag_q[1] == cur_d);
    hit_d  = hit0_d || hit1_d;
    nbuf_d = (valid_q[0] && (tag_q[0] == nxt_d))
          || (valid_q[1] && (tag_q[1] == nxt_d));
    sel_d  = hit1_d ? word_q[1] : word_q[0];
    byte_d = rom_addr[0] ? sel_d[15:8] : sel_d[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      valid_q   <= 2'b00;
      tag_q[0]  <= '0;
      tag_q[1]  <= '0;
      word_q[0] <= '0;
      word_q[1] <= '0;
      lru_q     <= 1'b0;
      req_q     <= 1'b0;
      maddr_q   <= '0;
      discard_q <= 1'b0;
      ok_q      <= 1'b0;
      data_q    <= '0;
      addr_q    <= '0;
    end else begin
      ok_q   <= rom_cs && hit_d && !flush;
      data_q <= byte_d;
      addr_q <= rom_addr;
      if (rom_cs && hit_d) lru_q <= hit0_d;
      if (flush) valid_q <= 2'b00;
      unique case (state_q)
        IDLE: begin
          if (rom_cs && !hit_d) begin
            req_q   <= 1'b1;
            maddr_q <= cur_d;
            state_q <= FETCH;
          end else if (PREFETCH && rom_cs && hit_d && !nbuf_d) begin
            req_q   <= 1'b1;
            maddr_q <= nxt_d;
            state_q <= PREF;
          end
        end
        FETCH, PREF: begin
          if (mem_ack) begin
            req_q     <= 1'b0;
            state_q   <= IDLE;
            discard_q <= 1'b0;
            // a flush seen during or with the ack drops the word
            if (!flush && !discard_q) begin
              valid_q[lru_q] <= 1'b1;
              tag_q[lru_q]   <= maddr_q;
              word_q[lru_q]  <= mem_data;
              lru_q          <= ~lru_q;
            end
          end else if (flush) begin
            discard_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_req  = req_q;
  assign mem_addr = maddr_q;
  assign rom_data = data_q;
  assign rom_ok   = ok_q && (rom_addr == addr_q);

endmodule
